mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single Avalon-MM master,
// with round-robin tie breaking and a read-response watchdog.
module mem_arbiter #(
  parameter int RAM_ADDR_W = 26,
  parameter int RAM_DATA_W = 128,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ready,
  input  logic                  avl_wait,
  input  logic                  avl_readdatavalid,
  input  logic [RAM_DATA_W-1:0] avl_readdata,
  output logic                  avl_read,
  output logic                  avl_write,
  output logic [RAM_ADDR_W-1:0] avl_address,
  output logic [RAM_DATA_W-1:0] avl_writedata,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

  state_t           state, state_nxt;
  logic             last_grant;   // 1 = data port won the last grant
  logic             gnt_d;        // port owning the transaction in flight
  logic [CNT_W-1:0] cnt;

  logic i_elig, d_elig;
  logic do_grant, sel_d, sel_wr;
  logic rd_accept, wr_done, rd_done, rd_tmo;

  logic unused_ok;
  assign unused_ok = ^{i_addr, d_addr, avl_readdata};

  assign avl_read  = (state == RD_CMD);
  assign avl_write = (state == WR_CMD);

  function automatic logic [DATA_W-1:0] tmo_word();
    return DATA_W'(32'hDEADBEEF);
  endfunction

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    sel_d     = 1'b0;
    sel_wr    = 1'b0;
    rd_accept = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    rd_tmo    = 1'b0;
    // A port whose ready is high this cycle has just been served; skip it.
    i_elig    = i_req & ~i_ready;
    d_elig    = (d_read | d_write) & ~d_ready;
    case (state)
      IDLE: begin
        if (i_elig || d_elig) begin
          do_grant  = 1'b1;
          sel_d     = d_elig & (~i_elig | ~last_grant);
          sel_wr    = sel_d & d_write;
          state_nxt = sel_wr ? WR_CMD : RD_CMD;
        end
      end
      RD_CMD: begin
        if (!avl_wait) begin
          rd_accept = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      WR_CMD: begin
        if (!avl_wait) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (avl_readdatavalid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rd_tmo    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      last_grant    <= 1'b0;
      gnt_d         <= 1'b0;
      cnt           <= '0;
      avl_address   <= '0;
      avl_writedata <= '0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      bus_err <= 1'b0;
      if (do_grant) begin
        gnt_d       <= sel_d;
        last_grant  <= sel_d;
        avl_address <= sel_d ? d_addr[RAM_ADDR_W-1:0] : i_addr[RAM_ADDR_W-1:0];
        if (sel_wr) avl_writedata <= RAM_DATA_W'(d_wdata);
      end
      if (rd_accept)                   cnt <= '0;
      else if (state == RD_WAIT)       cnt <= cnt + 1'b1;
      if (wr_done) d_ready <= 1'b1;
      if (rd_done || rd_tmo) begin
        if (gnt_d) begin
          d_rdata <= rd_tmo ? tmo_word() : avl_readdata[DATA_W-1:0];
          d_ready <= 1'b1;
        end else begin
          i_rdata <= rd_tmo ? tmo_word() : avl_readdata[DATA_W-1:0];
          i_ready <= 1'b1;
        end
        bus_err <= rd_tmo;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, stalled write, contention, timeout,
// reset mid-read and combined read+write requests.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_req = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [31:0]  i_rdata;
  logic         i_ready;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [31:0]  d_wdata = '0;
  logic [31:0]  d_rdata;
  logic         d_ready;
  logic         avl_wait = 1'b0;
  logic         avl_readdatavalid = 1'b0;
  logic [127:0] avl_readdata = '0;
  logic         avl_read;
  logic         avl_write;
  logic [25:0]  avl_address;
  logic [127:0] avl_writedata;
  logic         bus_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .iCLK(clk), .iRST_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .avl_wait(avl_wait), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .avl_read(avl_read), .avl_write(avl_write),
    .avl_address(avl_address), .avl_writedata(avl_writedata), .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_avl_read"},  avl_read,      0);
    chk({tag, "_avl_write"}, avl_write,     0);
    chk({tag, "_avl_addr"},  avl_address,   0);
    chk({tag, "_avl_wdata"}, avl_writedata, 0);
    chk({tag, "_i_ready"},   i_ready,       0);
    chk({tag, "_d_ready"},   d_ready,       0);
    chk({tag, "_bus_err"},   bus_err,       0);
    chk({tag, "_i_rdata"},   i_rdata,       0);
    chk({tag, "_d_rdata"},   d_rdata,       0);
  endtask

  initial begin
    // Reset
    step();
    step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Instruction fetch
    i_req = 1'b1; i_addr = 32'h40; avl_wait = 1'b0;
    step();
    chk("fetch_avl_read", avl_read, 1);
    chk("fetch_addr", avl_address, 26'h40);
    i_req = 1'b0;
    step();
    chk("fetch_read_once", avl_read, 0);
    step();
    step();
    chk("fetch_no_early_ready", i_ready, 0);
    avl_readdatavalid = 1'b1;
    avl_readdata = 128'hFFFF0000_11112222_33334444_12345678;
    step();
    avl_readdatavalid = 1'b0;
    chk("fetch_i_ready", i_ready, 1);
    chk("fetch_i_rdata", i_rdata, 32'h12345678);
    chk("fetch_d_ready", d_ready, 0);
    step();
    chk("fetch_ready_pulse", i_ready, 0);
    chk("fetch_rdata_hold", i_rdata, 32'h12345678);

    // Stalled write
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D; avl_wait = 1'b1;
    step();
    d_write = 1'b0;
    chk("wr_avl_write_c1", avl_write, 1);
    chk("wr_addr", avl_address, 26'h100);
    chk("wr_wdata", avl_writedata, 128'h0000CAFEF00D);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wr_avl_write_held", avl_write, 1);
      chk("wr_no_early_ready", d_ready, 0);
    end
    avl_wait = 1'b0;
    step();
    chk("wr_accept_write_low", avl_write, 0);
    chk("wr_d_ready", d_ready, 1);
    chk("wr_wdata_stable", avl_writedata, 128'h0000CAFEF00D);
    step();
    chk("wr_ready_pulse", d_ready, 0);

    // Contention after reset: D, I, D, I
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h300; d_read = 1'b1; d_addr = 32'h200;
    avl_readdatavalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("rr_avl_read", avl_read, 1);
      chk("rr_addr", avl_address, (t % 2 == 0) ? 26'h200 : 26'h300);
      step();
      avl_readdata = 128'hA0 + 128'(t);
      step();
      chk("rr_d_ready", d_ready, (t % 2 == 0) ? 1 : 0);
      chk("rr_i_ready", i_ready, (t % 2 == 0) ? 0 : 1);
      if (t % 2 == 0) chk("rr_d_rdata", d_rdata, 32'hA0 + 32'(t));
      else            chk("rr_i_rdata", i_rdata, 32'hA0 + 32'(t));
      if (t == 3) begin
        i_req = 1'b0; d_read = 1'b0;
      end
    end
    avl_readdatavalid = 1'b0;
    step();
    chk("rr_quiet", avl_read, 0);

    // Read timeout
    d_read = 1'b1; d_addr = 32'h10;
    step();
    d_read = 1'b0;
    step();
    for (int k = 0; k < 1023; k++) step();
    chk("tmo_not_yet_ready", d_ready, 0);
    chk("tmo_not_yet_err", bus_err, 0);
    step();
    chk("tmo_d_ready", d_ready, 1);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("tmo_i_rdata_kept", i_rdata, 32'hA3);
    step();
    chk("tmo_ready_pulse", d_ready, 0);
    chk("tmo_err_pulse", bus_err, 0);

    // Reset while in RD_WAIT
    i_req = 1'b1; i_addr = 32'h80;
    step();
    i_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    step();
    rst_n = 1'b1;
    avl_readdatavalid = 1'b1; avl_readdata = 128'h55;
    step();
    avl_readdatavalid = 1'b0;
    chk("rst_late_i_ready", i_ready, 0);
    chk("rst_late_d_ready", d_ready, 0);
    chk("rst_late_i_rdata", i_rdata, 0);

    // Read+write together, tied with a fetch right after reset: data wins
    i_req = 1'b1; i_addr = 32'h90;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h44; d_wdata = 32'h77;
    step();
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    chk("rw_avl_write", avl_write, 1);
    chk("rw_no_avl_read", avl_read, 0);
    chk("rw_addr", avl_address, 26'h44);
    step();
    chk("rw_d_ready", d_ready, 1);
    chk("rw_accept_read", avl_read, 0);
    step();
    chk("rw_done_read", avl_read, 0);
    chk("rw_done_write", avl_write, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
